rram_adc_packer: RTL
====================

# rram_adc_packer

Downstream stage of the RRAM crossbar controller's read path. On a capture strobe it samples all thermometer-coded ADC outputs from the crossbar and converts each to a binary count. It packs the counts into DATAOUT_WIDTH-bit words and pushes them, in order, into the output data FIFO through an active-low push / full handshake. It also flags malformed thermometer codes.

## Interface
- NUM_ADC, 32, number of shared column ADCs
- ADC_WIDTH_THERM, 15, thermometer code width per ADC
- ADC_WIDTH, 4, binary result width per ADC; ADC_WIDTH_THERM must equal 2^ADC_WIDTH-1
- DATAOUT_WIDTH, 64, output FIFO word width; NUM_ADC*ADC_WIDTH must be a multiple of DATAOUT_WIDTH
- CLK  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- capture  in  1  one-cycle request from controller to sample ADCOUT_THERM
- clear_err  in  1  clears therm_err
- ADCOUT_THERM  in  NUM_ADC x ADC_WIDTH_THERM  unpacked array of ADC thermometer outputs
- busy  out  1  high while a frame is in flight
- push_n_oFIFO  out  1  active-low push to output FIFO
- full_oFIFO  in  1  output FIFO full
- din_oFIFO  out  DATAOUT_WIDTH  data word to output FIFO
- therm_err  out  1  sticky: a non-contiguous thermometer code was captured
- frame_cnt  out  16  completed frames, wraps 0xFFFF->0

## Operation
- WORDS = NUM_ADC*ADC_WIDTH/DATAOUT_WIDTH (2 by default); NPW = DATAOUT_WIDTH/ADC_WIDTH (16).
- FSM states: IDLE, CONV, PUSH.
- IDLE: busy=0. When capture=1, register all ADCOUT_THERM and go to CONV.
- In any other state, capture is ignored. It is not queued.
- CONV: convert each ADC code to a binary value equal to its popcount (0..15), then register it. Go to PUSH with word index = 0.
- Bubble check, done in CONV: a code is valid only if it has the form 0..01..1, with the ones contiguous from the LSB (all-zero is valid).
  - Any invalid code sets therm_err.
  - The popcount is still used for invalid codes.
- PUSH: din_oFIFO = word[idx], where ADC i maps to word i/NPW, bits [ADC_WIDTH*(i%NPW) +: ADC_WIDTH]. The lowest ADC index is in the LSBs.
- PUSH: push_n_oFIFO = !full_oFIFO (combinational from the state register and full).
  - On each edge with push_n_oFIFO low, idx increments.
  - After the push of the last word (idx = WORDS-1), frame_cnt increments and the FSM returns to IDLE.
- While full_oFIFO is high, push_n_oFIFO stays high and din_oFIFO and idx hold. No word is dropped or duplicated.
- therm_err clears on clear_err. If clear_err and a new bubble detection occur in the same cycle, set wins.
- busy = (state != IDLE).

## Timing
- Reset values: push_n_oFIFO=1, din_oFIFO=0, busy=0, therm_err=0, frame_cnt=0, state=IDLE, idx=0.
- If capture is sampled at edge E0, the FSM is in CONV after E0 and in PUSH after E1.
- Word 0 is pushed at E2 and word 1 at E3, assuming full_oFIFO is low. The FSM is in IDLE after E3.
- Minimum capture-to-capture spacing is WORDS+2 cycles. A capture at E3 is ignored; the earliest accepted next capture is at E4.
- Each cycle with full_oFIFO high in PUSH adds exactly one cycle of latency.
- din_oFIFO is a registered/muxed value that is stable throughout PUSH. Outside PUSH it holds the last value.
- ADCOUT_THERM only needs to be valid in the cycle capture is sampled. Later changes do not affect the frame.
- Reset asserted mid-frame:
  - The FSM returns to IDLE at the next edge and push_n_oFIFO goes high.
  - The partial frame is discarded, and frame_cnt and therm_err are cleared.
- frame_cnt increments at the same edge as the last word's push.

## Test plan
- All ADC = 15'h7FFF, single capture, full_oFIFO=0 -> push_n low two consecutive cycles starting 2 cycles after capture; words 64'hFFFF_FFFF_FFFF_FFFF twice; therm_err=0; frame_cnt=1.
- ADC i = (1<<(i%16))-1 -> word0 = word1 = 64'hFEDC_BA98_7654_3210; therm_err=0.
- All ADC = 15'b010101010101001 -> each nibble 7, both words 64'h7777_7777_7777_7777; therm_err=1 and stays 1 until a clear_err pulse, then 0.
- full_oFIFO held high for 5 cycles on entering PUSH -> push_n stays 1, din holds word0. Then full released -> word0 and word1 each pushed exactly once, in order; busy falls after word1.
- capture pulsed again during CONV and during PUSH -> ignored; exactly 2 pushes and frame_cnt increments by 1.
- capture with full_oFIFO=0, then reset asserted in the cycle word0 is pushed -> push_n=1 and busy=0 after the next edge, no word1 pushed, frame_cnt=0. A new capture after reset completes normally.

Source files
------------

// File: rtl/rram_adc_packer.sv
// Samples all thermometer-coded column ADC outputs on a capture strobe, converts
// each to a binary count, and streams the packed counts into the output FIFO.
module rram_adc_packer #(
  parameter int NUM_ADC         = 32,
  parameter int ADC_WIDTH_THERM = 15,
  parameter int ADC_WIDTH       = 4,
  parameter int DATAOUT_WIDTH   = 64
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic                       capture,
  input  logic                       clear_err,
  input  logic [ADC_WIDTH_THERM-1:0] ADCOUT_THERM [NUM_ADC],
  output logic                       busy,
  output logic                       push_n_oFIFO,
  input  logic                       full_oFIFO,
  output logic [DATAOUT_WIDTH-1:0]   din_oFIFO,
  output logic                       therm_err,
  output logic [15:0]                frame_cnt,
  output logic [1:0]                 dbg_state_o
);

  localparam int FRAME_W = NUM_ADC * ADC_WIDTH;
  localparam int WORDS   = FRAME_W / DATAOUT_WIDTH;
  localparam int IDX_W   = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_PUSH = 2'd2
  } state_t;

  // FIFO handshake: a word is transferred on every rising edge where
  // push_n_oFIFO is low; push_n_oFIFO is low only in PUSH while full is low.

  state_t                     state_q;
  logic [ADC_WIDTH_THERM-1:0] therm_q [NUM_ADC];
  logic [FRAME_W-1:0]         words_q;
  logic [IDX_W-1:0]           idx_q;
  logic [DATAOUT_WIDTH-1:0]   din_q;
  logic                       err_q;
  logic [15:0]                frame_q;

  logic [FRAME_W-1:0]         conv_words;
  logic                       bubble;
  logic                       err_set;
  logic [DATAOUT_WIDTH-1:0]   nxt_word;
  logic                       push_fire;

  // A valid code is 0..01..1, so adding one leaves no bit in common with it.
  function automatic logic is_bubble(input logic [ADC_WIDTH_THERM-1:0] code);
    logic [ADC_WIDTH_THERM:0] code_ext;
    code_ext = {1'b0, code};
    return (code_ext & (code_ext + (ADC_WIDTH_THERM+1)'(1))) != '0;
  endfunction

  always_comb begin
    conv_words = '0;
    bubble     = 1'b0;
    for (int i = 0; i < NUM_ADC; i++) begin
      conv_words[i*ADC_WIDTH +: ADC_WIDTH] = ADC_WIDTH'($countones(therm_q[i]));
      if (is_bubble(therm_q[i])) bubble = 1'b1;
    end
  end

  always_comb begin
    nxt_word = '0;
    for (int w = 1; w < WORDS; w++) begin
      if (idx_q == IDX_W'(w - 1)) nxt_word = words_q[w*DATAOUT_WIDTH +: DATAOUT_WIDTH];
    end
  end

  assign err_set   = (state_q == S_CONV) && bubble;
  assign push_fire = (state_q == S_PUSH) && !full_oFIFO;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      din_q   <= '0;
      err_q   <= 1'b0;
      frame_q <= '0;
    end else begin
      if (err_set)        err_q <= 1'b1;
      else if (clear_err) err_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (capture) begin
            therm_q <= ADCOUT_THERM;
            state_q <= S_CONV;
          end
        end
        S_CONV: begin
          words_q <= conv_words;
          din_q   <= conv_words[DATAOUT_WIDTH-1:0];
          idx_q   <= '0;
          state_q <= S_PUSH;
        end
        S_PUSH: begin
          if (push_fire) begin
            if (idx_q == IDX_W'(WORDS - 1)) begin
              // din keeps the last word so the FIFO bus is quiet in IDLE.
              idx_q   <= '0;
              frame_q <= frame_q + 16'd1;
              state_q <= S_IDLE;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
              din_q <= nxt_word;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign push_n_oFIFO = !push_fire;
  assign din_oFIFO    = din_q;
  assign therm_err    = err_q;
  assign frame_cnt    = frame_q;
  assign dbg_state_o  = state_q;

endmodule
